// File: rtl/highlow_ni_monitor_if.sv
// Monitor-side bundle: lockstep CPU observations in, FSM state and violation record out.
interface highlow_ni_monitor_if #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 1,
    parameter int CNT_W    = 16
);
    localparam int IDX_W = $clog2(NUM_REGS + 1);

    logic                             enable_i;
    logic                             clear_i;
    logic [NUM_REGS-1:0][DATA_W-1:0]  val1_i;
    logic [NUM_REGS-1:0]              lbl1_i;
    logic [NUM_REGS-1:0][DATA_W-1:0]  val2_i;
    logic [NUM_REGS-1:0]              lbl2_i;
    logic [DATA_W-1:0]                low1_i;
    logic [DATA_W-1:0]                low2_i;
    logic [1:0]                       state_o;
    logic                             violation_o;
    logic                             viol_kind_o;
    logic [IDX_W-1:0]                 viol_index_o;
    logic [CNT_W-1:0]                 viol_cycle_o;
    logic [CNT_W-1:0]                 cycle_cnt_o;
    logic [CNT_W-1:0]                 checks_cnt_o;

    modport master (
        output enable_i, clear_i, val1_i, lbl1_i, val2_i, lbl2_i, low1_i, low2_i,
        input  state_o, violation_o, viol_kind_o, viol_index_o, viol_cycle_o,
               cycle_cnt_o, checks_cnt_o
    );

    modport slave (
        input  enable_i, clear_i, val1_i, lbl1_i, val2_i, lbl2_i, low1_i, low2_i,
        output state_o, violation_o, viol_kind_o, viol_index_o, viol_cycle_o,
               cycle_cnt_o, checks_cnt_o
    );
endinterface

// File: rtl/highlow_ni_monitor.sv
// Non-interference monitor for two lockstep CPUs: checks low-labelled register pairs and
// low outputs every enabled CHECK cycle and latches the first breach in a sticky record.
module highlow_ni_monitor #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 1,
    parameter int WARMUP   = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    highlow_ni_monitor_if.slave  mon
);
    localparam int IDX_W  = $clog2(NUM_REGS + 1);
    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP > 0) ? WARMUP - 1 : 0);

    typedef enum logic [1:0] {IDLE = 2'd0, WARM = 2'd1, CHECK = 2'd2, FAIL = 2'd3} state_t;
    localparam state_t START = (WARMUP == 0) ? CHECK : WARM;

    state_t            state;
    logic [WARM_W-1:0] warm_cnt;
    logic              violation;
    logic              viol_kind;
    logic [IDX_W-1:0]  viol_index;
    logic [CNT_W-1:0]  viol_cycle;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  checks_cnt;

    logic [NUM_REGS-1:0] reg_breach;
    logic                out_breach;
    logic                breach;
    logic [IDX_W-1:0]    first_idx;
    logic [IDX_W-1:0]    idx_sel;

    // A pair only matters when at least one copy is low; then value and label must agree.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_pair
        assign reg_breach[k] = (!mon.lbl1_i[k] || !mon.lbl2_i[k]) &&
                               ((mon.val1_i[k] != mon.val2_i[k]) ||
                                (mon.lbl1_i[k] != mon.lbl2_i[k]));
    end

    assign out_breach = (mon.low1_i != mon.low2_i);
    assign breach     = out_breach || (|reg_breach);

    always_comb begin
        first_idx = IDX_W'(NUM_REGS);
        for (int k = NUM_REGS - 1; k >= 0; k--)
            if (reg_breach[k]) first_idx = IDX_W'(k);
    end

    assign idx_sel = out_breach ? IDX_W'(NUM_REGS) : first_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            warm_cnt   <= '0;
            violation  <= 1'b0;
            viol_kind  <= 1'b0;
            viol_index <= '0;
            viol_cycle <= '0;
            cycle_cnt  <= '0;
            checks_cnt <= '0;
        end else if (mon.clear_i) begin
            state      <= START;
            warm_cnt   <= '0;
            violation  <= 1'b0;
            viol_kind  <= 1'b0;
            viol_index <= '0;
            viol_cycle <= '0;
            cycle_cnt  <= '0;
            checks_cnt <= '0;
        end else if (mon.enable_i) begin
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
            case (state)
                IDLE: begin
                    state    <= START;
                    warm_cnt <= '0;
                end
                WARM: begin
                    if (warm_cnt == WARM_LAST) state <= CHECK;
                    else warm_cnt <= warm_cnt + 1'b1;
                end
                CHECK: begin
                    if (checks_cnt != '1) checks_cnt <= checks_cnt + 1'b1;
                    if (breach) begin
                        state      <= FAIL;
                        violation  <= 1'b1;
                        viol_kind  <= out_breach;
                        viol_index <= idx_sel;
                        viol_cycle <= cycle_cnt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mon.state_o      = state;
    assign mon.violation_o  = violation;
    assign mon.viol_kind_o  = viol_kind;
    assign mon.viol_index_o = viol_index;
    assign mon.viol_cycle_o = viol_cycle;
    assign mon.cycle_cnt_o  = cycle_cnt;
    assign mon.checks_cnt_o = checks_cnt;
endmodule
